// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite initiator: turns single-word commands from a valid/ready command
// port into AXI4-Lite write or read transactions, one outstanding at a time,
// and returns BRESP/RRESP (plus read data) on a valid/ready response port.
module axi_lite_master_engine #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT_VALUE = 3'b000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI4-Lite write channels
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  // AXI4-Lite read channels
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  // Next-state and registered-output logic; every handshake output is a flop.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr;
          if (cmd_rnw) begin
            arvalid_d = 1'b1;
            state_d   = READ;
          end else begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently; B is only accepted once both have.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      READ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          rdata_d     = M_AXI_RDATA;
          resp_d      = M_AXI_RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so it never depends combinationally on cmd_valid.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_VALUE;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_VALUE;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Testbench for axi_lite_master_engine with a small AXI4-Lite slave model
// whose AW/W/AR ready delays are adjustable per test.
module tb_axi_lite_master_engine;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_master_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VALUE(3'b000)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic [31:0] mem [16];
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID  && (w_cnt  >= w_dly);
  assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
  assign BRESP   = 2'b00;
  assign wr_addr = (AWVALID && AWREADY) ? AWADDR : aw_a;
  assign wr_data = (WVALID && WREADY) ? WDATA : w_d;
  assign wr_strb = (WVALID && WREADY) ? WSTRB : w_s;

  // Slave: counts wait cycles, stores the write once AW and W both arrived,
  // answers B/R one cycle after the completing handshake. Address 0x10
  // always reads back with SLVERR.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
      BVALID <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
    end else begin
      if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (WVALID && !WREADY)   w_cnt  <= w_cnt + 1;  else w_cnt  <= 0;
      if (ARVALID && !ARREADY) ar_cnt <= ar_cnt + 1; else ar_cnt <= 0;
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_a <= AWADDR; end
      if (WVALID && WREADY) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !BVALID) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        BVALID <= 1'b1;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= mem[ARADDR[5:2]];
        RRESP  <= (ARADDR == 32'h10) ? 2'b10 : 2'b00;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int          aw_hi = 0, w_hi = 0, b_hi = 0, aw_unst = 0, rsp_hs = 0;
  logic        aw_seen = 1'b0;
  logic [31:0] aw_prev = '0;

  // Per-cycle valid/ready occupancy and AWADDR stability while AWVALID.
  always @(negedge ACLK) begin
    if (AWVALID) aw_hi <= aw_hi + 1;
    if (WVALID)  w_hi  <= w_hi + 1;
    if (BREADY)  b_hi  <= b_hi + 1;
    if (AWVALID && aw_seen && AWADDR != aw_prev) aw_unst <= aw_unst + 1;
    aw_seen <= AWVALID;
    aw_prev <= AWADDR;
  end

  // Response handshakes delivered to the consumer.
  always @(posedge ACLK) begin
    if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready) begin
        @(posedge ACLK);
        ok = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    #1 cmd_valid = 1'b0;
    check("cmd_accept", {255'd0, ok}, 256'd1);
  endtask

  // Returns at the falling edge on which rsp_valid is first seen; lat counts
  // cycles after the accepting edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge ACLK);
      lat++;
      if (rsp_valid) break;
    end
    check("rsp_arrives", {255'd0, rsp_valid}, 256'd1);
  endtask

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        vecs[12];
  int          lat, a0, w0, b0, r0, u0;
  logic [31:0] held;

  initial begin
    vecs[0]  = '{1'b0, 32'h0,  32'h1,        4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h4,  32'h2,        4'hF, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 32'h8,  32'h3,        4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1'b0, 32'hC,  32'h4,        4'hF, 32'h0,        2'b00};
    vecs[4]  = '{1'b1, 32'h0,  32'h0,        4'h0, 32'h1,        2'b00};
    vecs[5]  = '{1'b1, 32'h4,  32'h0,        4'h0, 32'h2,        2'b00};
    vecs[6]  = '{1'b1, 32'h8,  32'h0,        4'h0, 32'h3,        2'b00};
    vecs[7]  = '{1'b1, 32'hC,  32'h0,        4'h0, 32'h4,        2'b00};
    vecs[8]  = '{1'b0, 32'h10, 32'h55,       4'hF, 32'h0,        2'b00};
    vecs[9]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'h55,       2'b10};
    vecs[10] = '{1'b0, 32'h4,  32'hAABBCCDD, 4'h3, 32'h0,        2'b00};
    vecs[11] = '{1'b1, 32'h4,  32'h0,        4'h0, 32'h0000CCDD, 2'b00};

    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

    // Reset state: every output low, including cmd_ready.
    @(negedge ACLK);
    check("reset_outputs",
          {115'd0, cmd_ready, rsp_valid, rsp_rdata, rsp_resp, AWVALID, WVALID, BREADY,
           ARVALID, RREADY, AWADDR, ARADDR, WDATA, WSTRB, AWPROT, ARPROT}, 256'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("cmd_ready_after_reset", {255'd0, cmd_ready}, 256'd1);

    // Table: writes, read-backs, SLVERR pass-through, partial strobes.
    for (int i = 0; i < 12; i++) begin
      send_cmd(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      wait_rsp(lat);
      check($sformatf("v%0d_rdata", i), {224'd0, rsp_rdata}, {224'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_resp", i), {254'd0, rsp_resp}, {254'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_latency", i), 256'(lat), 256'd3);
      @(posedge ACLK); #1;
      check($sformatf("v%0d_cmd_ready_after", i), {254'd0, cmd_ready, rsp_valid}, 256'd2);
    end

    // AWREADY held off 5 cycles, WREADY immediate.
    aw_dly = 5; w_dly = 0;
    a0 = aw_hi; w0 = w_hi; b0 = b_hi; r0 = rsp_hs; u0 = aw_unst;
    send_cmd(1'b0, 32'h14, 32'h77, 4'hF);
    wait_rsp(lat);
    check("awstall_latency", 256'(lat), 256'd8);
    check("awstall_resp", {254'd0, rsp_resp}, 256'd0);
    @(posedge ACLK); #1;
    check("awstall_aw_cycles", 256'(aw_hi - a0), 256'd6);
    check("awstall_w_cycles", 256'(w_hi - w0), 256'd1);
    check("awstall_bready_cycles", 256'(b_hi - b0), 256'd1);
    check("awstall_responses", 256'(rsp_hs - r0), 256'd1);
    check("awstall_awaddr_stable", 256'(aw_unst - u0), 256'd0);

    // The reverse: WREADY held off 5 cycles, AWREADY immediate.
    aw_dly = 0; w_dly = 5;
    a0 = aw_hi; w0 = w_hi; b0 = b_hi; r0 = rsp_hs;
    send_cmd(1'b0, 32'h18, 32'h99, 4'hF);
    wait_rsp(lat);
    @(posedge ACLK); #1;
    check("wstall_aw_cycles", 256'(aw_hi - a0), 256'd1);
    check("wstall_w_cycles", 256'(w_hi - w0), 256'd6);
    check("wstall_bready_cycles", 256'(b_hi - b0), 256'd1);
    check("wstall_responses", 256'(rsp_hs - r0), 256'd1);
    w_dly = 0;
    send_cmd(1'b1, 32'h18, 32'h0, 4'h0);
    wait_rsp(lat);
    check("wstall_readback", {224'd0, rsp_rdata}, 256'h99);
    @(posedge ACLK); #1;

    // Consumer stalls 10 cycles: response held, no new command accepted.
    @(negedge ACLK);
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h14, 32'h0, 4'h0);
    wait_rsp(lat);
    held = rsp_rdata;
    check("stall_rdata", {224'd0, held}, 256'h77);
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      check($sformatf("stall_hold_%0d", k), {221'd0, rsp_valid, rsp_rdata, rsp_resp, cmd_ready},
            {221'd0, 1'b1, 32'h77, 2'b00, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    check("stall_release", {254'd0, cmd_ready, rsp_valid}, 256'd2);

    // Reset asserted while ARVALID is high.
    ar_dly = 20;
    send_cmd(1'b1, 32'h8, 32'h0, 4'h0);
    @(negedge ACLK);
    check("arvalid_before_reset", {255'd0, ARVALID}, 256'd1);
    ARESETN = 1'b0;
    #1;
    check("midreset_outputs",
          {121'd0, cmd_ready, rsp_valid, rsp_rdata, rsp_resp, AWVALID, WVALID, BREADY,
           ARVALID, RREADY, AWADDR, ARADDR, WDATA, WSTRB}, 256'd0);
    ar_dly = 0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    r0 = rsp_hs;
    b0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (rsp_valid) b0++;
    end
    check("no_rsp_after_reset", 256'(b0), 256'd0);
    send_cmd(1'b1, 32'h8, 32'h0, 4'h0);
    wait_rsp(lat);
    check("post_reset_rdata", {224'd0, rsp_rdata}, 256'h3);
    check("post_reset_resp", {254'd0, rsp_resp}, 256'd0);
    check("post_reset_latency", 256'(lat), 256'd3);
    @(posedge ACLK); #1;
    check("post_reset_responses", 256'(rsp_hs - r0), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
